fifo_sync_param: RTL and testbench

- Single-clock, parametrised successor to the 36-bit/512-deep FIFO used between path-tracer pipeline stages (ray generator -> intersector -> shader).
- Width, depth and almost-full/almost-empty thresholds are parameters.
- Adds an occupancy count, a first-word-fall-through (FWFT) option, a synchronous flush, and sticky overflow/underflow error flags.
- Memory is an inferable simple dual-port block RAM with no reset on the array.

---
 rtl/fifo_sync_param.sv | 116 +++++++++++
 tb/tb_fifo_sync_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, optional first-word-fall-through,
// synchronous flush and sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned AF_THRESH  = 494,
  parameter int unsigned AE_THRESH  = 8,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_accept, rd_accept, mem_load, mem_empty;

  logic [WIDTH-1:0] mem_q [Depth];

  // Flags decode straight from the registered count.
  always_comb begin
    full         = (count_q == CntW'(Depth));
    almost_full  = (count_q >= CntW'(AF_THRESH));
    almost_empty = (count_q <= CntW'(AE_THRESH));
    empty        = FWFT ? ~rd_valid_q : (count_q == '0);
    // In FWFT mode the head register holds one of the counted words.
    mem_empty    = FWFT ? ((count_q - CntW'(rd_valid_q)) == '0) : (count_q == '0);
    wr_accept    = wr_en & ~full & ~flush;
    rd_accept    = FWFT ? (rd_en & rd_valid_q & ~flush) : (rd_en & ~empty & ~flush);
    mem_load     = FWFT ? ((~rd_valid_q | rd_accept) & ~mem_empty & ~flush) : rd_accept;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rd_valid_d  = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (mem_load) begin
        rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      rd_valid_d = FWFT ? (mem_load | (rd_valid_q & ~rd_accept)) : rd_accept;
      if (wr_accept && !rd_accept) begin
        count_d = count_q + CntW'(1);
      end else if (!wr_accept && rd_accept) begin
        count_d = count_q - CntW'(1);
      end
      overflow_d  = overflow_q | (wr_en & full);
      underflow_d = underflow_q | (rd_en & empty);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised bench for fifo_sync_param: one standard-read and one FWFT instance, each checked
// every cycle against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int W  = 36;
  localparam int DL = 9;
  localparam int D  = 512;
  localparam int AF = 494;
  localparam int AE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          f0 = 0, we0 = 0, re0 = 0, f1 = 0, we1 = 0, re1 = 0;
  logic [W-1:0]  wd0 = '0, wd1 = '0;
  logic          full0, af0, rv0, emp0, ae0, ovf0, unf0;
  logic          full1, af1, rv1, emp1, ae1, ovf1, unf1;
  logic [W-1:0]  rdd0, rdd1;
  logic [DL:0]   cnt0, cnt1;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(W), .DEPTH_LOG2(DL), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0))
  u_std (
    .clk(clk), .rst(rst), .flush(f0), .wr_en(we0), .wr_data(wd0), .full(full0),
    .almost_full(af0), .rd_en(re0), .rd_data(rdd0), .rd_valid(rv0), .empty(emp0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.WIDTH(W), .DEPTH_LOG2(DL), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1))
  u_fwft (
    .clk(clk), .rst(rst), .flush(f1), .wr_en(we1), .wr_data(wd1), .full(full1),
    .almost_full(af1), .rd_en(re1), .rd_data(rdd1), .rd_valid(rv1), .empty(emp1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference state: stored words in order, plus visible output register and sticky flags.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] md0, md1;
  bit           mv0, mv1, mo0, mo1, mu0, mu1;

  task automatic reset_models();
    q0.delete(); q1.delete();
    md0 = '0; md1 = '0;
    mv0 = 0; mv1 = 0; mo0 = 0; mo1 = 0; mu0 = 0; mu1 = 0;
  endtask

  task automatic model_std(input bit f, input bit w, input logic [W-1:0] d, input bit r);
    bit was_full, was_empty;
    if (f) begin
      q0.delete(); mv0 = 0; mo0 = 0; mu0 = 0;
    end else begin
      was_full  = (q0.size() == D);
      was_empty = (q0.size() == 0);
      mv0 = 0;
      if (r && was_empty) mu0 = 1;
      if (w && was_full) mo0 = 1;
      if (r && !was_empty) begin
        md0 = q0.pop_front();
        mv0 = 1;
      end
      if (w && !was_full) q0.push_back(d);
    end
  endtask

  // The head becomes visible one edge after a word is stored; a pop shows the next stored word.
  task automatic model_fwft(input bit f, input bit w, input logic [W-1:0] d, input bit r);
    bit was_full;
    if (f) begin
      q1.delete(); mv1 = 0; mo1 = 0; mu1 = 0;
    end else begin
      was_full = (q1.size() == D);
      if (r && !mv1) mu1 = 1;
      if (w && was_full) mo1 = 1;
      if (r && mv1) void'(q1.pop_front());
      mv1 = (q1.size() > 0);
      if (mv1) md1 = q1[0];
      if (w && !was_full) q1.push_back(d);
    end
  endtask

  task automatic check_all();
    check("std.count", 64'(cnt0), 64'(q0.size()));
    check("std.full", 64'(full0), 64'(q0.size() == D));
    check("std.almost_full", 64'(af0), 64'(q0.size() >= AF));
    check("std.almost_empty", 64'(ae0), 64'(q0.size() <= AE));
    check("std.empty", 64'(emp0), 64'(q0.size() == 0));
    check("std.rd_valid", 64'(rv0), 64'(mv0));
    check("std.rd_data", 64'(rdd0), 64'(md0));
    check("std.overflow", 64'(ovf0), 64'(mo0));
    check("std.underflow", 64'(unf0), 64'(mu0));
    check("fwft.count", 64'(cnt1), 64'(q1.size()));
    check("fwft.full", 64'(full1), 64'(q1.size() == D));
    check("fwft.almost_full", 64'(af1), 64'(q1.size() >= AF));
    check("fwft.almost_empty", 64'(ae1), 64'(q1.size() <= AE));
    check("fwft.empty", 64'(emp1), 64'(!mv1));
    check("fwft.rd_valid", 64'(rv1), 64'(mv1));
    check("fwft.rd_data", 64'(rdd1), 64'(md1));
    check("fwft.overflow", 64'(ovf1), 64'(mo1));
    check("fwft.underflow", 64'(unf1), 64'(mu1));
  endtask

  task automatic step(input bit a_f, input bit a_w, input logic [W-1:0] a_d, input bit a_r,
                      input bit b_f, input bit b_w, input logic [W-1:0] b_d, input bit b_r);
    f0 = a_f; we0 = a_w; wd0 = a_d; re0 = a_r;
    f1 = b_f; we1 = b_w; wd1 = b_d; re1 = b_r;
    @(posedge clk);
    model_std(a_f, a_w, a_d, a_r);
    model_fwft(b_f, b_w, b_d, b_r);
    #1;
    check_all();
  endtask

  task automatic st0(input bit f, input bit w, input logic [W-1:0] d, input bit r);
    step(f, w, d, r, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic st1(input bit f, input bit w, input logic [W-1:0] d, input bit r);
    step(1'b0, 1'b0, '0, 1'b0, f, w, d, r);
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {4'($urandom), 32'($urandom)};
  endfunction

  initial begin
    int writes, iter;
    bit w, r;
    reset_models();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst = 1'b1;

    // Fill the standard instance with 0..511.
    for (int i = 0; i < D; i++) begin
      st0(1'b0, 1'b1, W'(i), 1'b0);
      if (i == AF - 2) check("af_below_494", 64'(af0), 64'd0);
      if (i == AF - 1) check("af_at_494", 64'(af0), 64'd1);
    end
    check("full_at_512", 64'(full0), 64'd1);
    check("count_at_512", 64'(cnt0), 64'd512);
    st0(1'b0, 1'b1, 36'hDEAD, 1'b0);
    check("overflow_513th", 64'(ovf0), 64'd1);
    check("count_after_drop", 64'(cnt0), 64'd512);

    // Drain in order, one cycle latency.
    for (int i = 0; i < D; i++) begin
      st0(1'b0, 1'b0, '0, 1'b1);
      check("drain_data", 64'(rdd0), 64'(i));
      check("drain_valid", 64'(rv0), 64'd1);
    end
    check("drain_empty", 64'(emp0), 64'd1);
    st0(1'b0, 1'b0, '0, 1'b1);
    check("underflow_extra", 64'(unf0), 64'd1);
    check("valid_on_underflow", 64'(rv0), 64'd0);

    // Simultaneous write/read at empty, then at full.
    st0(1'b1, 1'b0, '0, 1'b0);
    check("flush_clears_flags", 64'({ovf0, unf0}), 64'd0);
    st0(1'b0, 1'b1, 36'h123, 1'b1);
    check("empty_wr_rd_count", 64'(cnt0), 64'd1);
    check("empty_wr_rd_underflow", 64'(unf0), 64'd1);
    for (int i = 0; i < D - 1; i++) st0(1'b0, 1'b1, rnd_word(), 1'b0);
    st0(1'b0, 1'b1, 36'h55, 1'b1);
    check("full_wr_rd_count", 64'(cnt0), 64'd511);
    check("full_wr_rd_overflow", 64'(ovf0), 64'd1);
    check("full_wr_rd_data", 64'(rdd0), 64'h123);

    // Wrap-around: 600 writes interleaved with reads, occupancy 1..20.
    st0(1'b1, 1'b0, '0, 1'b0);
    writes = 0;
    iter = 0;
    while (writes < 600 && iter < 5000) begin
      w = (q0.size() < 20) && (q0.size() == 0 || ($urandom % 3) != 0);
      r = (q0.size() >= 2 || (q0.size() == 1 && w)) && ($urandom % 2 == 1);
      st0(1'b0, w, rnd_word(), r);
      if (w) writes++;
      iter++;
    end
    check("wrap_writes_done", 64'(writes), 64'd600);

    // Flush dominates a same-cycle write.
    st0(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) st0(1'b0, 1'b1, rnd_word(), 1'b0);
    check("count_100", 64'(cnt0), 64'd100);
    st0(1'b1, 1'b1, 36'hBEEF, 1'b0);
    check("flush_count", 64'(cnt0), 64'd0);
    check("flush_empty", 64'(emp0), 64'd1);
    st0(1'b0, 1'b0, '0, 1'b1);
    check("flush_no_write", 64'(rv0), 64'd0);

    // FWFT: word visible one edge after it is written into an empty FIFO.
    st1(1'b0, 1'b1, 36'hA5, 1'b0);
    check("fwft_not_yet_valid", 64'(rv1), 64'd0);
    st1(1'b0, 1'b0, '0, 1'b0);
    check("fwft_valid", 64'(rv1), 64'd1);
    check("fwft_head_a5", 64'(rdd1), 64'hA5);
    for (int k = 1; k <= 4; k++) st1(1'b0, 1'b1, W'(k), 1'b0);
    for (int k = 1; k <= 5; k++) begin
      st1(1'b0, 1'b0, '0, 1'b1);
      if (k < 5) check("fwft_pop_data", 64'(rdd1), 64'(k));
      check("fwft_pop_valid", 64'(rv1), 64'(k < 5));
    end
    st1(1'b0, 1'b0, '0, 1'b1);
    check("fwft_underflow", 64'(unf1), 64'd1);

    // Random traffic on both instances with occasional flushes.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 64) == 0, ($urandom % 4) != 0, rnd_word(), ($urandom % 2) == 1,
           ($urandom % 64) == 0, ($urandom % 2) == 1, rnd_word(), ($urandom % 3) != 0);
    end

    // Asynchronous reset mid-burst, between clock edges.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, rnd_word(), 1'b0, 1'b0, 1'b1, rnd_word(), 1'b0);
    #1 rst = 1'b0;
    #1;
    reset_models();
    check_all();
    #2 rst = 1'b1;
    st0(1'b0, 1'b1, 36'h777, 1'b0);
    st0(1'b0, 1'b0, '0, 1'b1);
    check("post_reset_first_word", 64'(rdd0), 64'h777);
    st1(1'b0, 1'b1, 36'h888, 1'b0);
    st1(1'b0, 1'b0, '0, 1'b0);
    check("post_reset_fwft_word", 64'(rdd1), 64'h888);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
